// File: rtl/first_nios2_system_sysid_pkg.sv
// Shared types and constants for the system-ID boot checker.
package first_nios2_system_sysid_pkg;

   // Sequencer states, fixed 3-bit encoding.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RD_ID = 3'd1,
      ST_RD_TS = 3'd2,
      ST_CHECK = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   // err_code values.
   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_ID      = 2'd1;
   localparam logic [1:0] ERR_TS      = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

   // Word select on the sysid slave.
   localparam logic SYSID_ADDR_ID = 1'b0;
   localparam logic SYSID_ADDR_TS = 1'b1;

   // A sequence is in flight in these states.
   function automatic logic is_busy(input state_e s);
      return (s == ST_RD_ID) || (s == ST_RD_TS) || (s == ST_CHECK);
   endfunction

   // A start request may only be taken in these states.
   function automatic logic can_start(input state_e s);
      return (s == ST_IDLE) || (s == ST_DONE);
   endfunction

endpackage

// File: rtl/first_nios2_system_sysid_timeout.sv
// Per-read stall counter. Cleared while no read is pending or when a read
// completes, counts cycles the slave stalls, and flags when the stall budget
// has been used up. The count saturates at the limit.
module first_nios2_system_sysid_timeout
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic stall,
   output logic expired
);

   localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES);

   logic [15:0] count_q;
   logic [15:0] count_d;

   // Next count: clear has priority, otherwise count stalled cycles up to the limit.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = 16'd0;
      end else if (stall && (count_q != LIMIT)) begin
         count_d = count_q + 16'd1;
      end else begin
         count_d = count_q;
      end
   end

   // Counter register with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= 16'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired = (count_q == LIMIT);

endmodule

// File: rtl/first_nios2_system_sysid_checker.sv
// Boot-time system-ID checker: reads the ID and timestamp words from the sysid
// slave over Avalon-MM, compares them with build-time values and reports
// pass/fail. Stalled reads time out and the whole sequence is retried a
// bounded number of times. start is registered on the edge it is sampled and
// acted on one cycle later, so a read strobe follows a start by one cycle.
module first_nios2_system_sysid_checker
   import first_nios2_system_sysid_pkg::*;
#(
   parameter logic [31:0] EXPECTED_ID    = 32'd0,
   parameter logic [31:0] EXPECTED_TS    = 32'd1457643642,
   parameter bit          CHECK_TS       = 1'b1,
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned MAX_RETRIES    = 3,
   parameter bit          AUTO_START     = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic        fail,
   output logic [1:0]  err_code,
   output logic [31:0] id_value,
   output logic [31:0] ts_value
);

   localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRIES);

   state_e      state_q, state_d;
   logic        start_q;
   logic        auto_q;
   logic        read_q, read_d;
   logic        addr_q, addr_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        pass_q, pass_d;
   logic        fail_q, fail_d;
   logic [1:0]  err_q, err_d;
   logic [31:0] id_q, id_d;
   logic [31:0] ts_q, ts_d;
   logic [3:0]  retries_q, retries_d;

   logic launch_s;
   logic complete_s;
   logic expired_s;
   logic tmo_clear_s;
   logic tmo_stall_s;

   assign launch_s    = (start_q || auto_q) && can_start(state_q);
   assign complete_s  = read_q && !avm_waitrequest;
   assign tmo_clear_s = !read_q || complete_s;
   assign tmo_stall_s = read_q && avm_waitrequest;

   first_nios2_system_sysid_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clock   (clock),
      .reset   (reset),
      .clear   (tmo_clear_s),
      .stall   (tmo_stall_s),
      .expired (expired_s)
   );

   // Next-state, read strobe, captures and result flags.
   always_comb begin
      state_d   = state_q;
      read_d    = read_q;
      addr_d    = addr_q;
      done_d    = done_q;
      pass_d    = pass_q;
      fail_d    = fail_q;
      err_d     = err_q;
      id_d      = id_q;
      ts_d      = ts_q;
      retries_d = retries_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (launch_s) begin
               state_d   = ST_RD_ID;
               read_d    = 1'b1;
               addr_d    = SYSID_ADDR_ID;
               done_d    = 1'b0;
               pass_d    = 1'b0;
               fail_d    = 1'b0;
               err_d     = ERR_NONE;
               retries_d = 4'd0;
            end else begin
               state_d = state_q;
            end
         end

         ST_RD_ID, ST_RD_TS: begin
            if (!read_q) begin
               // One idle cycle after a timeout: retry from the ID word or give up.
               id_d = 32'd0;
               ts_d = 32'd0;
               if (retries_q < RETRY_LIMIT) begin
                  retries_d = retries_q + 4'd1;
                  state_d   = ST_RD_ID;
                  read_d    = 1'b1;
                  addr_d    = SYSID_ADDR_ID;
               end else begin
                  state_d = ST_DONE;
                  addr_d  = SYSID_ADDR_ID;
                  done_d  = 1'b1;
                  pass_d  = 1'b0;
                  fail_d  = 1'b1;
                  err_d   = ERR_TIMEOUT;
               end
            end else if (complete_s) begin
               if (state_q == ST_RD_ID) begin
                  id_d    = avm_readdata;
                  state_d = ST_RD_TS;
                  addr_d  = SYSID_ADDR_TS;
                  read_d  = 1'b1;
               end else begin
                  ts_d    = avm_readdata;
                  state_d = ST_CHECK;
                  addr_d  = SYSID_ADDR_ID;
                  read_d  = 1'b0;
               end
            end else if (expired_s) begin
               read_d = 1'b0;
            end else begin
               read_d = 1'b1;
            end
         end

         ST_CHECK: begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            if (id_q != EXPECTED_ID) begin
               err_d  = ERR_ID;
               pass_d = 1'b0;
               fail_d = 1'b1;
            end else if (CHECK_TS && (ts_q != EXPECTED_TS)) begin
               err_d  = ERR_TS;
               pass_d = 1'b0;
               fail_d = 1'b1;
            end else begin
               err_d  = ERR_NONE;
               pass_d = 1'b1;
               fail_d = 1'b0;
            end
         end

         default: begin
            state_d = ST_IDLE;
            read_d  = 1'b0;
            addr_d  = SYSID_ADDR_ID;
         end
      endcase

      busy_d = is_busy(state_d);
   end

   // State and output registers; reset clears everything on the sampling edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         start_q   <= 1'b0;
         auto_q    <= AUTO_START;
         read_q    <= 1'b0;
         addr_q    <= SYSID_ADDR_ID;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         fail_q    <= 1'b0;
         err_q     <= ERR_NONE;
         id_q      <= 32'd0;
         ts_q      <= 32'd0;
         retries_q <= 4'd0;
      end else begin
         state_q   <= state_d;
         start_q   <= start && can_start(state_q);
         auto_q    <= 1'b0;
         read_q    <= read_d;
         addr_q    <= addr_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         pass_q    <= pass_d;
         fail_q    <= fail_d;
         err_q     <= err_d;
         id_q      <= id_d;
         ts_q      <= ts_d;
         retries_q <= retries_d;
      end
   end

   assign avm_address = addr_q;
   assign avm_read    = read_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign pass        = pass_q;
   assign fail        = fail_q;
   assign err_code    = err_q;
   assign id_value    = id_q;
   assign ts_value    = ts_q;

endmodule

// File: tb/tb_first_nios2_system_sysid_checker.sv
// Bench for the sysid checker: two instances in lockstep (timestamp check on
// and off) sharing one behavioural slave; expected results go through a queue.
module tb_first_nios2_system_sysid_checker;

   localparam logic [31:0] EXP_ID = 32'd0;
   localparam logic [31:0] EXP_TS = 32'd1457643642;

   logic        clk     = 1'b0;
   logic        reset   = 1'b1;
   logic        start   = 1'b0;
   logic        wait_r  = 1'b0;
   logic [31:0] id_word = EXP_ID;
   logic [31:0] ts_word = EXP_TS;

   logic a_addr, a_read, a_busy, a_done, a_pass, a_fail;
   logic b_addr, b_read, b_busy, b_done, b_pass, b_fail;
   logic [1:0]  a_err, b_err;
   logic [31:0] a_id, a_ts, b_id, b_ts, a_rdata, b_rdata;

   int vectors     = 0;
   int miscompares = 0;
   logic [68:0] exp_q[$];

   always #5 clk = ~clk;

   assign a_rdata = a_addr ? ts_word : id_word;
   assign b_rdata = b_addr ? ts_word : id_word;

   first_nios2_system_sysid_checker #(
      .CHECK_TS(1'b1), .TIMEOUT_CYCLES(4), .MAX_RETRIES(2)
   ) u_dut_a (
      .clock(clk), .reset(reset), .start(start),
      .avm_address(a_addr), .avm_read(a_read), .avm_waitrequest(wait_r), .avm_readdata(a_rdata),
      .busy(a_busy), .done(a_done), .pass(a_pass), .fail(a_fail), .err_code(a_err),
      .id_value(a_id), .ts_value(a_ts)
   );

   first_nios2_system_sysid_checker #(
      .CHECK_TS(1'b0), .TIMEOUT_CYCLES(4), .MAX_RETRIES(2)
   ) u_dut_b (
      .clock(clk), .reset(reset), .start(start),
      .avm_address(b_addr), .avm_read(b_read), .avm_waitrequest(wait_r), .avm_readdata(b_rdata),
      .busy(b_busy), .done(b_done), .pass(b_pass), .fail(b_fail), .err_code(b_err),
      .id_value(b_id), .ts_value(b_ts)
   );

   function automatic logic [68:0] res_a();
      return {a_done, a_pass, a_fail, a_err, a_id, a_ts};
   endfunction

   function automatic logic [68:0] res_b();
      return {b_done, b_pass, b_fail, b_err, b_id, b_ts};
   endfunction

   // Reference result {done,pass,fail,err,id,ts} for one completed sequence.
   function automatic logic [68:0] model(input logic [31:0] id, input logic [31:0] ts,
                                         input bit chk, input bit tmo);
      logic [1:0]  e;
      logic [31:0] idc, tsc;
      idc = id;
      tsc = ts;
      if (tmo) begin
         e = 2'd3; idc = 32'd0; tsc = 32'd0;
      end else if (id !== EXP_ID) e = 2'd1;
      else if (chk && (ts !== EXP_TS)) e = 2'd2;
      else e = 2'd0;
      return {1'b1, (e == 2'd0), (e != 2'd0), e, idc, tsc};
   endfunction

   function automatic void push_pair();
      exp_q.push_back(model(id_word, ts_word, 1'b1, 1'b0));
      exp_q.push_back(model(id_word, ts_word, 1'b0, 1'b0));
   endfunction

   // Waits (bounded) until both instances report done.
   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         if (a_done && b_done) begin ok = 1'b1; break; end
         @(negedge clk);
      end
   endtask

   // Pulses start, then follows the sequence until done while counting read cycles.
   task automatic run_seq(input int budget, output bit ok, output int id_reads, output int ts_reads);
      ok = 1'b0; id_reads = 0; ts_reads = 0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      for (int c = 0; c < budget; c++) begin
         if (a_done && b_done) begin ok = 1'b1; break; end
         if (a_read && !a_addr) id_reads++;
         if (a_read && a_addr) ts_reads++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      bit ok;
      logic [68:0] ev;
      reset = 1'b1; start = 1'b0; wait_r = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if ({a_addr, a_read, a_busy, res_a()} !== 72'd0) begin
         miscompares++; $display("FAIL reset_state_a got=%h required=0", {a_addr, a_read, a_busy, res_a()});
      end
      vectors++;
      if ({b_addr, b_read, b_busy, res_b()} !== 72'd0) begin
         miscompares++; $display("FAIL reset_state_b got=%h required=0", {b_addr, b_read, b_busy, res_b()});
      end
      push_pair();
      reset = 1'b0;
      @(negedge clk);
      vectors++;
      if ({a_read, a_addr, a_busy} !== 3'b101) begin
         miscompares++; $display("FAIL auto_start_read got=%b required=101", {a_read, a_addr, a_busy});
      end
      wait_done(20, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL auto_start_done got=0 required=1"); end
      ev = exp_q.pop_front(); vectors++;
      if (res_a() !== ev) begin miscompares++; $display("FAIL auto_start_a got=%h required=%h", res_a(), ev); end
      ev = exp_q.pop_front(); vectors++;
      if (res_b() !== ev) begin miscompares++; $display("FAIL auto_start_b got=%h required=%h", res_b(), ev); end
   endtask

   task automatic test_zero_wait();
      logic [68:0] ev;
      id_word = EXP_ID; ts_word = EXP_TS;
      push_pair();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;                       // cycle N
      vectors++;
      if (a_read !== 1'b0) begin miscompares++; $display("FAIL t1_cycN_read got=%b required=0", a_read); end
      @(negedge clk); vectors++;                          // cycle N+1: ID read
      if ({a_read, a_addr, a_busy, a_done} !== 4'b1010) begin
         miscompares++; $display("FAIL t1_cycN1 got=%b required=1010", {a_read, a_addr, a_busy, a_done});
      end
      @(negedge clk); vectors++;                          // cycle N+2: TS read
      if ({a_read, a_addr, a_busy, a_done} !== 4'b1110) begin
         miscompares++; $display("FAIL t1_cycN2 got=%b required=1110", {a_read, a_addr, a_busy, a_done});
      end
      @(negedge clk); vectors++;                          // cycle N+3: CHECK
      if ({a_read, a_busy, a_done} !== 3'b010) begin
         miscompares++; $display("FAIL t1_cycN3 got=%b required=010", {a_read, a_busy, a_done});
      end
      @(negedge clk);                                     // cycle N+4: results
      ev = exp_q.pop_front(); vectors++;
      if ({a_busy, res_a()} !== {1'b0, ev}) begin
         miscompares++; $display("FAIL t1_result_a got=%h required=%h", {a_busy, res_a()}, {1'b0, ev});
      end
      ev = exp_q.pop_front(); vectors++;
      if (res_b() !== ev) begin miscompares++; $display("FAIL t1_result_b got=%h required=%h", res_b(), ev); end
   endtask

   task automatic test_mismatch(input logic [31:0] idw, input logic [31:0] tsw, input string tag);
      bit ok;
      int idr, tsr;
      logic [68:0] ev;
      id_word = idw; ts_word = tsw;
      push_pair();
      run_seq(20, ok, idr, tsr);
      vectors++;
      if (!ok || idr != 1 || tsr != 1) begin
         miscompares++; $display("FAIL %s_reads done=%b id_reads=%0d ts_reads=%0d required 1/1/1", tag, ok, idr, tsr);
      end
      ev = exp_q.pop_front(); vectors++;
      if (res_a() !== ev) begin miscompares++; $display("FAIL %s_a got=%h required=%h", tag, res_a(), ev); end
      ev = exp_q.pop_front(); vectors++;
      if (res_b() !== ev) begin miscompares++; $display("FAIL %s_b got=%h required=%h", tag, res_b(), ev); end
      id_word = EXP_ID; ts_word = EXP_TS;
   endtask

   task automatic test_timeout();
      logic [18:0] obs, expv;
      logic        addr_seen;
      logic [68:0] ev;
      for (int i = 0; i < 19; i++) expv[i] = (i != 0) && (((i - 1) % 6) < 5);
      exp_q.push_back(model(id_word, ts_word, 1'b1, 1'b1));
      exp_q.push_back(model(id_word, ts_word, 1'b0, 1'b1));
      wait_r = 1'b1; addr_seen = 1'b0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int i = 0; i < 19; i++) begin
         obs[i] = a_read;
         addr_seen = addr_seen | a_addr;
         @(negedge clk);
      end
      wait_r = 1'b0;
      vectors++;
      if ({addr_seen, obs} !== {1'b0, expv}) begin
         miscompares++; $display("FAIL t4_read_trace got=%b required=%b", {addr_seen, obs}, {1'b0, expv});
      end
      ev = exp_q.pop_front(); vectors++;
      if (res_a() !== ev) begin miscompares++; $display("FAIL t4_result_a got=%h required=%h", res_a(), ev); end
      ev = exp_q.pop_front(); vectors++;
      if (res_b() !== ev) begin miscompares++; $display("FAIL t4_result_b got=%h required=%h", res_b(), ev); end
   endtask

   task automatic test_ts_stall();
      bit ok;
      int stalls, ts_cycles, id_reads, bad;
      logic [68:0] ev;
      push_pair();
      stalls = 0; ts_cycles = 0; id_reads = 0; ok = 1'b0; bad = 0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (c > 0 && a_done && b_done) begin ok = 1'b1; break; end
         if (a_read && a_addr) begin
            ts_cycles++;
            wait_r = (stalls < 3);
            if (stalls < 3) stalls++;
         end else begin
            wait_r = 1'b0;
         end
         if (a_read && !a_addr) id_reads++;
         start = (c == 2) || (c == 4);
         @(negedge clk);
      end
      start = 1'b0; wait_r = 1'b0;
      vectors++;
      if (!ok || ts_cycles != 4 || id_reads != 1) begin
         miscompares++; $display("FAIL t5_stall done=%b ts_cycles=%0d id_reads=%0d required 1/4/1", ok, ts_cycles, id_reads);
      end
      ev = exp_q.pop_front(); vectors++;
      if (res_a() !== ev) begin miscompares++; $display("FAIL t5_result_a got=%h required=%h", res_a(), ev); end
      ev = exp_q.pop_front(); vectors++;
      if (res_b() !== ev) begin miscompares++; $display("FAIL t5_result_b got=%h required=%h", res_b(), ev); end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (a_read || !a_done || a_busy) bad++;
      end
      vectors++;
      if (bad != 0) begin miscompares++; $display("FAIL t5_no_restart bad_cycles=%0d required=0", bad); end
   endtask

   task automatic test_reset_mid_read();
      bit ok, seen;
      logic [68:0] ev;
      seen = 1'b0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int c = 0; c < 10; c++) begin
         if (a_read && a_addr) begin seen = 1'b1; break; end
         @(negedge clk);
      end
      vectors++;
      if (!seen) begin miscompares++; $display("FAIL t6_ts_phase got=0 required=1"); end
      reset = 1'b1;
      @(negedge clk);
      vectors++;
      if ({a_addr, a_read, a_busy, res_a(), b_addr, b_read, b_busy, res_b()} !== 144'd0) begin
         miscompares++; $display("FAIL t6_reset_outputs got_a=%h got_b=%h required=0",
                                 {a_addr, a_read, a_busy, res_a()}, {b_addr, b_read, b_busy, res_b()});
      end
      reset = 1'b0;
      push_pair();
      @(negedge clk);
      vectors++;
      if ({a_read, a_addr, a_busy} !== 3'b101) begin
         miscompares++; $display("FAIL t6_restart_read got=%b required=101", {a_read, a_addr, a_busy});
      end
      wait_done(20, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL t6_done got=0 required=1"); end
      ev = exp_q.pop_front(); vectors++;
      if (res_a() !== ev) begin miscompares++; $display("FAIL t6_result_a got=%h required=%h", res_a(), ev); end
      ev = exp_q.pop_front(); vectors++;
      if (res_b() !== ev) begin miscompares++; $display("FAIL t6_result_b got=%h required=%h", res_b(), ev); end
   endtask

   task automatic test_back_to_back();
      int rises, bad;
      logic prev;
      logic [68:0] ev;
      push_pair(); push_pair();
      rises = 0; bad = 0;
      @(negedge clk); start = 1'b1;
      prev = a_done;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (a_done && !prev) begin
            rises++;
            ev = exp_q.pop_front(); vectors++;
            if (res_a() !== ev) begin miscompares++; $display("FAIL b2b_result_a got=%h required=%h", res_a(), ev); end
            ev = exp_q.pop_front(); vectors++;
            if (res_b() !== ev) begin miscompares++; $display("FAIL b2b_result_b got=%h required=%h", res_b(), ev); end
         end
         prev = a_done;
         if (rises == 2) begin start = 1'b0; break; end
      end
      start = 1'b0;
      vectors++;
      if (rises != 2) begin miscompares++; $display("FAIL b2b_done_count got=%0d required=2", rises); end
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (a_read || !a_done) bad++;
      end
      vectors++;
      if (bad != 0) begin miscompares++; $display("FAIL b2b_settle bad_cycles=%0d required=0", bad); end
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_mismatch(32'h0000_0001, EXP_TS, "t2_id_mismatch");
      test_mismatch(EXP_ID, 32'h5700_0000, "t3_ts_mismatch");
      test_timeout();
      test_ts_stall();
      test_reset_mid_read();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog simulation did not finish, vectors=%0d", vectors);
      $fatal(1);
   end

endmodule
